// File: rtl/mac_pkg.sv
// Shared definitions for the custom-0 INT8 SIMD MAC datapath and its sequencer.
package mac_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned DOT_W  = 18;

  localparam logic [6:0] CUSTOM0 = 7'b0001011;

  typedef enum logic [2:0] {
    StIdle,
    StFetchA,
    StFetchB,
    StAccum,
    StDone
  } mac_state_e;

endpackage

// File: rtl/simd_dot4.sv
// Four-lane signed INT8 dot product; purely combinational so the single-cycle
// MAC path can share it.
module simd_dot4
  import mac_pkg::*;
(
  input  logic [31:0]             a,
  input  logic [31:0]             b,
  output logic signed [DOT_W-1:0] dot
);

  localparam int unsigned ProdW = 2 * LANE_W;

  logic signed [ProdW-1:0] prod [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [ProdW-1:0] ea;
    logic signed [ProdW-1:0] eb;
    assign ea      = ProdW'($signed(a[i*LANE_W +: LANE_W]));
    assign eb      = ProdW'($signed(b[i*LANE_W +: LANE_W]));
    assign prod[i] = ea * eb;
  end

  // Sign-extend every lane product before summing.
  always_comb begin
    dot = '0;
    for (int i = 0; i < LANES; i++) begin
      dot = dot + DOT_W'(prod[i]);
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Multi-cycle sequencer for the custom-0 SIMD MAC: fetches word pairs over the
// shared req/gnt port, accumulates their dot products with saturation and
// stalls the pipeline until the result is ready for writeback.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_a,
  input  logic [31:0]      base_b,
  input  logic [LEN_W-1:0] len,
  input  logic             relu_en,
  output logic             busy,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_gnt,
  input  logic [31:0]      mem_rdata,
  output logic             done,
  output logic [31:0]      result,
  output logic             ovf
);

  // Sum width wide enough for both the accumulator and a full dot product.
  localparam int unsigned SumW = (ACC_W + 1 > DOT_W + 1) ? ACC_W + 1 : DOT_W + 1;
  localparam logic signed [SumW-1:0] AccMax = {{(SumW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SumW-1:0] AccMin = {{(SumW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  mac_state_e              state_q, state_d;
  logic [31:0]             base_a_q, base_a_d;
  logic [31:0]             base_b_q, base_b_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        idx_q, idx_d;
  logic                    relu_q, relu_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [31:0]             a_word_q, a_word_d;
  logic [31:0]             b_word_q, b_word_d;
  logic                    done_q, done_d;
  logic [31:0]             result_q, result_d;

  logic signed [DOT_W-1:0] dot;
  logic signed [SumW-1:0]  sum;
  logic signed [ACC_W-1:0] acc_sat;
  logic                    sat_hit;
  logic [31:0]             offset;

  simd_dot4 u_dot4 (
    .a   (a_word_q),
    .b   (b_word_q),
    .dot (dot)
  );

  assign offset = 32'(idx_q) << 2;

  // Saturating accumulate of the current word pair.
  always_comb begin
    sum     = SumW'(acc_q) + SumW'(dot);
    sat_hit = 1'b0;
    acc_sat = ACC_W'(sum);
    if (sum > AccMax) begin
      acc_sat = ACC_W'(AccMax);
      sat_hit = 1'b1;
    end else if (sum < AccMin) begin
      acc_sat = ACC_W'(AccMin);
      sat_hit = 1'b1;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    len_d    = len_q;
    idx_d    = idx_q;
    relu_d   = relu_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    a_word_d = a_word_q;
    b_word_d = b_word_q;
    done_d   = 1'b0;
    result_d = result_q;
    busy     = 1'b0;
    mem_req  = 1'b0;
    mem_addr = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Stall the issue cycle itself.
          busy     = 1'b1;
          base_a_d = {base_a[31:2], 2'b00};
          base_b_d = {base_b[31:2], 2'b00};
          len_d    = len;
          relu_d   = relu_en;
          acc_d    = '0;
          idx_d    = '0;
          ovf_d    = 1'b0;
          state_d  = (len != '0) ? StFetchA : StDone;
        end
      end
      StFetchA: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = base_a_q + offset;
        if (mem_gnt) begin
          a_word_d = mem_rdata;
          state_d  = StFetchB;
        end
      end
      StFetchB: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = base_b_q + offset;
        if (mem_gnt) begin
          b_word_d = mem_rdata;
          state_d  = StAccum;
        end
      end
      StAccum: begin
        busy    = 1'b1;
        acc_d   = acc_sat;
        ovf_d   = ovf_q | sat_hit;
        idx_d   = idx_q + LEN_W'(1);
        state_d = (idx_q == len_q - LEN_W'(1)) ? StDone : StFetchA;
      end
      StDone: begin
        // busy stays low so writeback can take the result.
        done_d   = 1'b1;
        result_d = (relu_q && acc_q[ACC_W-1]) ? 32'd0 : 32'(acc_q);
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset wins over a coincident grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      base_a_q <= '0;
      base_b_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      relu_q   <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      a_word_q <= '0;
      b_word_q <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      relu_q   <= relu_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      a_word_q <= a_word_d;
      b_word_q <= b_word_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: a default-width instance with a table-driven
// memory and programmable grant delay, plus an ACC_W=18 instance for saturation.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, relu_en, mem_gnt, busy, mem_req, done, ovf;
  logic [31:0] base_a, base_b, mem_addr, mem_rdata, result;
  logic [7:0]  len;

  logic        start18, busy18, req18, done18, ovf18;
  logic [31:0] addr18, result18;
  logic [31:0] rdata18;
  logic        gnt18;

  int checks = 0;
  int errors = 0;

  int gnt_delay = 0;
  int wait_cnt  = 0;

  logic [31:0] tab_addr [8];
  logic [31:0] tab_data [8];
  logic        tab_vld  [8];

  // Results captured by run_op.
  int          r_cyc;
  logic [31:0] r_res;
  logic        r_ovf, r_start_busy, r_stable, r_busy_ok, r_timeout, r_req_seen;
  logic [31:0] addr_q [$];

  always #5 clk = ~clk;

  mac_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_a    (base_a),
    .base_b    (base_b),
    .len       (len),
    .relu_en   (relu_en),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rdata (mem_rdata),
    .done      (done),
    .result    (result),
    .ovf       (ovf)
  );

  mac_seq_ctrl #(.LEN_W(8), .ACC_W(18)) dut18 (
    .clk       (clk),
    .rst       (rst),
    .start     (start18),
    .base_a    (32'h0000_1000),
    .base_b    (32'h0000_2000),
    .len       (8'd2),
    .relu_en   (1'b0),
    .busy      (busy18),
    .mem_req   (req18),
    .mem_addr  (addr18),
    .mem_gnt   (gnt18),
    .mem_rdata (rdata18),
    .done      (done18),
    .result    (result18),
    .ovf       (ovf18)
  );

  assign gnt18   = req18;
  assign rdata18 = 32'h8080_8080;

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      if (tab_vld[i] && tab_addr[i] == mem_addr) mem_rdata = tab_data[i];
    end
  end

  assign mem_gnt = mem_req && (wait_cnt >= gnt_delay);

  always @(posedge clk) begin
    if (mem_req && !mem_gnt) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  task automatic clear_mem();
    for (int i = 0; i < 8; i++) tab_vld[i] = 1'b0;
  endtask

  task automatic set_mem(input int i, input logic [31:0] a, input logic [31:0] d);
    tab_addr[i] = a;
    tab_data[i] = d;
    tab_vld[i]  = 1'b1;
  endtask

  // Issues one operation and watches it to completion; records cycles from the
  // start edge to the observed done pulse, granted addresses and handshake health.
  task automatic run_op(input logic [31:0] ba, input logic [31:0] bb, input logic [7:0] l,
                        input logic r);
    logic        prev_wait;
    logic [31:0] prev_addr;
    @(negedge clk);
    base_a = ba; base_b = bb; len = l; relu_en = r; start = 1'b1;
    #1 r_start_busy = busy;
    @(negedge clk);
    start = 1'b0;
    r_cyc = 0; addr_q.delete(); r_stable = 1'b1; r_busy_ok = 1'b1; r_req_seen = 1'b0;
    prev_wait = 1'b0; prev_addr = '0;
    while (!done && r_cyc < 500) begin
      if (mem_req) begin
        r_req_seen = 1'b1;
        if (!busy) r_busy_ok = 1'b0;
        if (prev_wait && mem_addr != prev_addr) r_stable = 1'b0;
        if (mem_gnt) addr_q.push_back(mem_addr);
        prev_wait = !mem_gnt;
        prev_addr = mem_addr;
      end else begin
        prev_wait = 1'b0;
      end
      @(negedge clk);
      r_cyc++;
    end
    r_timeout = !done;
    r_res     = result;
    r_ovf     = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, mem_req, done, ovf} !== 4'b0000 || mem_addr !== 32'd0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: busy=%b req=%b done=%b ovf=%b addr=%h result=%h want all 0",
               busy, mem_req, done, ovf, mem_addr, result);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    clear_mem();
    set_mem(0, 32'h1000, 32'h0102_0304);
    set_mem(1, 32'h2000, 32'h0101_0101);
    gnt_delay = 0;
    run_op(32'h1003, 32'h2001, 8'd1, 1'b0);
    checks++;
    if (r_timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout: no done seen"); end
    checks++;
    if (r_start_busy !== 1'b1) begin
      errors++; $display("FAIL basic_issue_busy: got %b want 1", r_start_busy);
    end
    checks++;
    if (addr_q.size() != 2 || addr_q[0] !== 32'h1000 || addr_q[1] !== 32'h2000) begin
      errors++; $display("FAIL basic_addrs: got %p want '{1000,2000}", addr_q);
    end
    checks++;
    if (r_cyc != 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", r_cyc); end
    checks++;
    if (r_res !== 32'd10 || r_ovf !== 1'b0) begin
      errors++; $display("FAIL basic_result: got %h ovf=%b want 0000000a ovf=0", r_res, r_ovf);
    end
  endtask

  task automatic test_relu();
    clear_mem();
    set_mem(0, 32'h1000, 32'hFFFF_FFFF);
    set_mem(1, 32'h2000, 32'h0202_0202);
    run_op(32'h1000, 32'h2000, 8'd1, 1'b0);
    checks++;
    if (r_res !== 32'hFFFF_FFF8 || r_ovf !== 1'b0) begin
      errors++; $display("FAIL relu_off: got %h ovf=%b want fffffff8 ovf=0", r_res, r_ovf);
    end
    run_op(32'h1000, 32'h2000, 8'd1, 1'b1);
    checks++;
    if (r_res !== 32'd0) begin errors++; $display("FAIL relu_on: got %h want 0", r_res); end
  endtask

  task automatic test_wait_states();
    logic [31:0] exp_a [6];
    exp_a = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208};
    clear_mem();
    set_mem(0, 32'h100, 32'h0101_0101);
    set_mem(1, 32'h104, 32'h0101_0101);
    set_mem(2, 32'h108, 32'h0101_0101);
    set_mem(3, 32'h200, 32'h0101_0101);
    set_mem(4, 32'h204, 32'h0202_0202);
    set_mem(5, 32'h208, 32'h0303_0303);
    // Grant lands on the second cycle of every request.
    gnt_delay = 1;
    run_op(32'h100, 32'h200, 8'd3, 1'b0);
    gnt_delay = 0;
    checks++;
    if (addr_q.size() != 6) begin
      errors++; $display("FAIL wait_addr_count: got %0d want 6", addr_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (addr_q[i] !== exp_a[i]) begin
          errors++; $display("FAIL wait_addr_%0d: got %h want %h", i, addr_q[i], exp_a[i]);
        end
      end
    end
    checks++;
    if (r_stable !== 1'b1 || r_busy_ok !== 1'b1) begin
      errors++; $display("FAIL wait_handshake: stable=%b busy_ok=%b want 1 1", r_stable, r_busy_ok);
    end
    checks++;
    if (r_cyc != 16) begin errors++; $display("FAIL wait_latency: got %0d want 16", r_cyc); end
    checks++;
    if (r_res !== 32'd24) begin errors++; $display("FAIL wait_result: got %h want 00000018", r_res); end
  endtask

  task automatic test_len0_wrap();
    run_op(32'h500, 32'h600, 8'd0, 1'b0);
    checks++;
    if (r_cyc != 1 || r_req_seen !== 1'b0) begin
      errors++; $display("FAIL len0: latency=%0d req_seen=%b want 1 0", r_cyc, r_req_seen);
    end
    checks++;
    if (r_res !== 32'd0 || r_ovf !== 1'b0) begin
      errors++; $display("FAIL len0_result: got %h ovf=%b want 0 0", r_res, r_ovf);
    end
    clear_mem();
    set_mem(0, 32'hFFFF_FFFC, 32'h0000_0001);
    set_mem(1, 32'h300,       32'h0000_0005);
    set_mem(2, 32'h0,         32'h0000_0002);
    set_mem(3, 32'h304,       32'h0000_0003);
    run_op(32'hFFFF_FFFC, 32'h300, 8'd2, 1'b0);
    checks++;
    if (addr_q.size() != 4 || addr_q[2] !== 32'h0 || addr_q[3] !== 32'h304) begin
      errors++; $display("FAIL wrap_addrs: got %p want '{fffffffc,300,0,304}", addr_q);
    end
    checks++;
    if (r_res !== 32'd11 || r_cyc != 7) begin
      errors++; $display("FAIL wrap_result: got %h lat=%0d want 0000000b lat=7", r_res, r_cyc);
    end
  endtask

  task automatic test_saturation();
    int cnt;
    @(negedge clk);
    start18 = 1'b1;
    @(negedge clk);
    start18 = 1'b0;
    cnt = 0;
    while (!done18 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (done18 !== 1'b1 || cnt != 7) begin
      errors++; $display("FAIL sat_latency: done=%b lat=%0d want 1 7", done18, cnt);
    end
    checks++;
    if (result18 !== 32'h0001_FFFF || ovf18 !== 1'b1) begin
      errors++; $display("FAIL sat_result: got %h ovf=%b want 0001ffff ovf=1", result18, ovf18);
    end
  endtask

  task automatic test_ignore_and_abort();
    int  cnt;
    logic bad;
    clear_mem();
    set_mem(0, 32'h1000, 32'h0102_0304);
    set_mem(1, 32'h1004, 32'h0102_0304);
    set_mem(2, 32'h2000, 32'h0101_0101);
    set_mem(3, 32'h2004, 32'h0101_0101);
    @(negedge clk);
    base_a = 32'h1000; base_b = 32'h2000; len = 8'd2; relu_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!(mem_req && mem_addr == 32'h2000) && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (!(mem_req && mem_addr == 32'h2000)) begin
      errors++; $display("FAIL abort_reach_fetch_b: req=%b addr=%h want 1 00002000", mem_req, mem_addr);
    end
    // Start with len=0 while in FETCH_B must not redirect to DONE.
    start = 1'b1; len = 8'd0; base_a = 32'h5000;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || mem_req !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ignore_start: busy=%b req=%b done=%b want 1 0 0", busy, mem_req, done);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || result !== 32'd0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_state: busy=%b req=%b result=%h done=%b want 0 0 0 0",
                         busy, mem_req, result, done);
    end
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || mem_req) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL abort_quiet: got activity=%b want 0", bad); end
    run_op(32'h1000, 32'h2000, 8'd2, 1'b0);
    checks++;
    if (r_res !== 32'd20 || r_cyc != 7) begin
      errors++; $display("FAIL after_abort: got %h lat=%0d want 00000014 lat=7", r_res, r_cyc);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start18 = 1'b0; relu_en = 1'b0;
    base_a = '0; base_b = '0; len = '0;
    clear_mem();
    test_reset();
    test_basic();
    test_relu();
    test_wait_states();
    test_len0_wrap();
    test_saturation();
    test_ignore_and_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
